// File: rtl/adder_response_checker.sv
// adder_response_checker
//
// On-chip response checker for a WIDTH-bit adder. Each accepted vector
// (a, b, cin plus the adder's y, cout) has its golden {carry,sum} computed
// and registered in stage 1, then compared in stage 2. Pass/fail counters,
// a sticky error flag and a copy of the first failing vector are kept.
// A run is armed by a start pulse and completes after expected_count
// vectors have been compared.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   start          one-cycle pulse: clear results, latch expected_count, arm
//   expected_count number of vectors in the run (sampled with start)
//   in_valid       vector present on a/b/cin/y/cout
//   in_ready       checker accepts a vector this cycle (registers only)
//   a, b, cin      operands applied to the adder under test
//   y, cout        adder result
//   busy, done     state is RUN / state is DONE
//   pass_count     number of matching vectors
//   fail_count     number of mismatching vectors
//   err            sticky, set once fail_count becomes nonzero
//   ff_a, ff_b, ff_cin, ff_got, ff_exp  first failing vector of the run
module adder_response_checker #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] expected_count,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [WIDTH-1:0] y,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             err,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic             ff_cin,
   output logic [WIDTH:0]   ff_got,
   output logic [WIDTH:0]   ff_exp
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] exp_reg;
   logic [CNT_W-1:0] acc_reg;

   logic             s1_valid_reg;
   logic [WIDTH:0]   s1_golden_reg;
   logic [WIDTH:0]   s1_got_reg;
   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;
   logic             s1_cin_reg;

   logic [CNT_W-1:0] pass_reg;
   logic [CNT_W-1:0] fail_reg;
   logic             err_reg;
   logic [WIDTH-1:0] ff_a_reg;
   logic [WIDTH-1:0] ff_b_reg;
   logic             ff_cin_reg;
   logic [WIDTH:0]   ff_got_reg;
   logic [WIDTH:0]   ff_exp_reg;

   logic             accept;
   logic [WIDTH:0]   golden_next;
   logic             s1_match;

   assign in_ready = (state_reg == RUN) && (acc_reg < exp_reg);
   // start has priority: a vector presented on the start edge is not taken
   assign accept   = in_valid && in_ready && !start;

   // Zero-extended operands so the carry out of the MSB lands in bit WIDTH
   assign golden_next = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign s1_match    = (s1_got_reg == s1_golden_reg);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (start) begin
         state_next = (expected_count == '0) ? DONE : RUN;
      end else begin
         case (state_reg)
            // Once every vector is accepted, the last one sits in stage 1
            // and is compared on the same edge that enters DONE.
            RUN:     if (acc_reg == exp_reg) state_next = DONE;
            default: state_next = state_reg;
         endcase
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_reg       <= '0;
         acc_reg       <= '0;
         s1_valid_reg  <= 1'b0;
         s1_golden_reg <= '0;
         s1_got_reg    <= '0;
         s1_a_reg      <= '0;
         s1_b_reg      <= '0;
         s1_cin_reg    <= 1'b0;
         pass_reg      <= '0;
         fail_reg      <= '0;
         err_reg       <= 1'b0;
         ff_a_reg      <= '0;
         ff_b_reg      <= '0;
         ff_cin_reg    <= 1'b0;
         ff_got_reg    <= '0;
         ff_exp_reg    <= '0;
      end else if (start) begin
         // Re-arm: any in-flight stage-1 vector is dropped
         exp_reg      <= expected_count;
         acc_reg      <= '0;
         s1_valid_reg <= 1'b0;
         pass_reg     <= '0;
         fail_reg     <= '0;
         err_reg      <= 1'b0;
         ff_a_reg     <= '0;
         ff_b_reg     <= '0;
         ff_cin_reg   <= 1'b0;
         ff_got_reg   <= '0;
         ff_exp_reg   <= '0;
      end else begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_golden_reg <= golden_next;
            s1_got_reg    <= {cout, y};
            s1_a_reg      <= a;
            s1_b_reg      <= b;
            s1_cin_reg    <= cin;
            acc_reg       <= acc_reg + CNT_W'(1);
         end
         if (s1_valid_reg) begin
            if (s1_match) begin
               pass_reg <= pass_reg + CNT_W'(1);
            end else begin
               fail_reg <= fail_reg + CNT_W'(1);
               err_reg  <= 1'b1;
               // Only the first failure of the run is captured
               if (fail_reg == '0) begin
                  ff_a_reg   <= s1_a_reg;
                  ff_b_reg   <= s1_b_reg;
                  ff_cin_reg <= s1_cin_reg;
                  ff_got_reg <= s1_got_reg;
                  ff_exp_reg <= s1_golden_reg;
               end
            end
         end
      end
   end

   assign pass_count = pass_reg;
   assign fail_count = fail_reg;
   assign err        = err_reg;
   assign ff_a       = ff_a_reg;
   assign ff_b       = ff_b_reg;
   assign ff_cin     = ff_cin_reg;
   assign ff_got     = ff_got_reg;
   assign ff_exp     = ff_exp_reg;

endmodule
